// File: rtl/pattern_scan_pkg.sv
// Shared encodings for the "01" pattern scanner: sequencer states and detector states.
package pattern_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // S0: previous bit was 1 (or there is none); S1: previous bit was 0
   typedef enum logic {
      S0 = 1'b0,
      S1 = 1'b1
   } det_t;

   function automatic det_t det_next(input logic a);
      return a ? S0 : S1;
   endfunction

endpackage

// File: rtl/pattern_scan_strobe_gen.sv
// Step-rate divider: tick is high on every DIV-th cycle while run is high.
module strobe_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] LAST = DW'(DIV - 1);

   logic [DW-1:0] div_r;

   // divider counter, wraps at DIV-1
   always_ff @(posedge clk) begin
      if (reset) begin
         div_r <= '0;
      end else if (clear) begin
         div_r <= '0;
      end else if (run) begin
         if (div_r == LAST) begin
            div_r <= '0;
         end else begin
            div_r <= div_r + DW'(1);
         end
      end else begin
         div_r <= div_r;
      end
   end

   assign tick = run & (div_r == LAST);

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Scans a word MSB first through a "01" detector and counts 0->1 transitions.
// Optional step-rate divider enabled by PATTERN_SCAN_CTRL_STROBE_EN.
module pattern_scan_ctrl
   import pattern_scan_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIV   = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] data,
   output logic             busy,
   output logic             done,
   output logic             match,
   output logic [CNT_W-1:0] count
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   state_t           state_r, state_next_s;
   det_t             det_r;
   logic [WIDTH-1:0] shift_r;
   logic [IDX_W-1:0] idx_r;
   logic [CNT_W-1:0] count_r;
   logic             busy_r, done_r, match_r;
   logic             accept_s, tick_s, step_s, bit_s, detect_s;

   assign accept_s = (state_r == IDLE) & start;

`ifdef PATTERN_SCAN_CTRL_STROBE_EN
   strobe_gen #(.DIV(DIV)) u_strobe (
      .clk   (clk),
      .reset (reset),
      .clear (accept_s),
      .run   (state_r == SHIFT),
      .tick  (tick_s)
   );
`else
   logic unused_div_s;
   assign unused_div_s = (DIV > 0);
   assign tick_s       = 1'b1;
`endif

   // abort wins over a step in the same cycle
   assign step_s   = (state_r == SHIFT) & tick_s & ~abort;
   assign bit_s    = shift_r[WIDTH-1];
   assign detect_s = step_s & bit_s & (det_r == S1);

   // next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_next_s = SHIFT;
            end else begin
               state_next_s = IDLE;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_next_s = IDLE;
            end else if (step_s && (idx_r == LAST_IDX)) begin
               state_next_s = DONE;
            end else begin
               state_next_s = SHIFT;
            end
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // state, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         det_r   <= S0;
         shift_r <= '0;
         idx_r   <= '0;
         count_r <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         match_r <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= (state_next_s == SHIFT);
         done_r  <= (state_next_s == DONE);
         match_r <= detect_s;
         if (accept_s) begin
            shift_r <= data;
            idx_r   <= '0;
            count_r <= '0;
            det_r   <= S0;
         end else if (step_s) begin
            shift_r <= {shift_r[WIDTH-2:0], 1'b0};
            idx_r   <= idx_r + IDX_W'(1);
            det_r   <= det_next(bit_s);
            if (detect_s) begin
               count_r <= count_r + CNT_W'(1);
            end else begin
               count_r <= count_r;
            end
         end else begin
            shift_r <= shift_r;
            idx_r   <= idx_r;
            count_r <= count_r;
            det_r   <= det_r;
         end
      end
   end

   assign busy  = busy_r;
   assign done  = done_r;
   assign match = match_r;
   assign count = count_r;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl; works with or without PATTERN_SCAN_CTRL_STROBE_EN.
module tb_pattern_scan_ctrl;

   localparam int WIDTH = 16;
   localparam int DIV   = 3;
   localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef PATTERN_SCAN_CTRL_STROBE_EN
   localparam int P = DIV;
`else
   localparam int P = 1;
`endif

   logic             clk = 1'b0;
   logic             reset, start, abort;
   logic [WIDTH-1:0] data;
   logic             busy, done, match;
   logic [CNT_W-1:0] count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int edge_no;
      int cnt;
   } done_exp_t;

   int        exp_match_q[$];
   done_exp_t exp_done_q[$];

   pattern_scan_ctrl #(.WIDTH(WIDTH), .DIV(DIV), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .abort (abort),
      .data  (data),
      .busy  (busy),
      .done  (done),
      .match (match),
      .count (count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: number of 0->1 transitions among the first nsteps bits read MSB first
   function automatic int ref_count(input logic [WIDTH-1:0] w, input int nsteps);
      int c = 0;
      for (int n = 1; n < nsteps; n++)
         if (w[WIDTH-1-n] == 1'b1 && w[WIDTH-n] == 1'b0) c++;
      return c;
   endfunction

   // Monitor: compares each match/done pulse to the scoreboard
   always @(negedge clk) begin
      if (!reset) begin
         if (match) begin
            check("match_edge", cyc, (exp_match_q.size() > 0) ? exp_match_q[0] : -1);
            if (exp_match_q.size() > 0 && exp_match_q[0] <= cyc) void'(exp_match_q.pop_front());
         end else if (exp_match_q.size() > 0 && exp_match_q[0] <= cyc) begin
            check("match_missing", int'(match), 1);
            void'(exp_match_q.pop_front());
         end
         if (done) begin
            check("done_edge", cyc, (exp_done_q.size() > 0) ? exp_done_q[0].edge_no : -1);
            check("done_count", int'(count), (exp_done_q.size() > 0) ? exp_done_q[0].cnt : -1);
            check("busy_at_done", int'(busy), 0);
            if (exp_done_q.size() > 0 && exp_done_q[0].edge_no <= cyc) void'(exp_done_q.pop_front());
         end else if (exp_done_q.size() > 0 && exp_done_q[0].edge_no <= cyc) begin
            check("done_missing", int'(done), 1);
            void'(exp_done_q.pop_front());
         end
      end
   end

   task automatic push_matches(input logic [WIDTH-1:0] w, input int k, input int nsteps);
      for (int n = 1; n < nsteps; n++)
         if (w[WIDTH-1-n] == 1'b1 && w[WIDTH-n] == 1'b0) exp_match_q.push_back(k + (n + 1) * P);
   endtask

   // One scan; abort_after<0 runs to completion, otherwise aborts after that many steps
   task automatic run_scan(input logic [WIDTH-1:0] w, input int abort_after,
                           input bit stray, input bit abort_at_start);
      int        k;
      int        exp_cnt;
      done_exp_t d;
      @(negedge clk);
      start = 1'b1;
      abort = abort_at_start;
      data  = w;
      k     = cyc + 1;
      if (abort_after < 0) begin
         exp_cnt = ref_count(w, WIDTH);
         push_matches(w, k, WIDTH);
         d.edge_no = k + WIDTH * P;
         d.cnt     = exp_cnt;
         exp_done_q.push_back(d);
      end else begin
         exp_cnt = ref_count(w, abort_after);
         push_matches(w, k, abort_after);
      end
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      data  = WIDTH'($urandom);
      check("busy_after_start", int'(busy), 1);
      if (abort_after >= 0) begin
         while (cyc < k + abort_after * P) @(negedge clk);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         repeat (3) @(negedge clk);
         check("abort_count", int'(count), exp_cnt);
         check("abort_busy", int'(busy), 0);
      end else begin
         if (stray) begin
            while (cyc < k + (WIDTH * P) / 2) @(negedge clk);
            start = 1'b1;
            data  = ~w;
            @(negedge clk);
            start = 1'b0;
         end
         while (cyc < k + WIDTH * P + 1) @(negedge clk);
         check("count_hold_idle", int'(count), exp_cnt);
         check("done_drained", exp_done_q.size(), 0);
      end
      check("match_drained", exp_match_q.size(), 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic reset_mid_scan();
      int k;
      @(negedge clk);
      start = 1'b1;
      data  = 16'h5555;
      k     = cyc + 1;
      push_matches(16'h5555, k, WIDTH);
      @(negedge clk);
      start = 1'b0;
      while (cyc < k + 5 * P) @(negedge clk);
      reset = 1'b1;
      exp_match_q.delete();
      exp_done_q.delete();
      @(negedge clk);
      check("rst_mid_busy", int'(busy), 0);
      check("rst_mid_done", int'(done), 0);
      check("rst_mid_match", int'(match), 0);
      check("rst_mid_count", int'(count), 0);
      reset = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout at edge %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] w;
      int               ab;
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      data  = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_match", int'(match), 0);
      check("rst_count", int'(count), 0);
      reset = 1'b0;

      run_scan(16'h5555, -1, 1'b0, 1'b0);
      run_scan(16'hFFFF, -1, 1'b0, 1'b0);
      run_scan(16'h0000, -1, 1'b0, 1'b0);
      run_scan(16'h8001, -1, 1'b0, 1'b0);
      run_scan(16'hF0F0, -1, 1'b0, 1'b0);
      run_scan(16'h5555, 6, 1'b0, 1'b0);
      run_scan(16'h5555, -1, 1'b1, 1'b1);
      reset_mid_scan();
      run_scan(16'h00FF, -1, 1'b0, 1'b0);

      for (int i = 0; i < 16; i++) begin
         w  = WIDTH'($urandom);
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WIDTH - 1)) : -1;
         run_scan(w, ab, (ab < 0) ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      check("final_match_q", exp_match_q.size(), 0);
      check("final_done_q", exp_done_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
